// File: rtl/xpmwrap_spram_ctrl.sv
// xpmwrap_spram_ctrl: arbitrates write and read requests onto a single-port
// RAM wrapper (read latency 2), and returns read data in request order
// through a small credit-protected response FIFO.
module xpmwrap_spram_ctrl #(
  parameter int unsigned ADDR_WIDTH_A = 6,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned RSP_DEPTH    = 4
) (
  input  logic                    clka,
  input  logic                    rsta_n,
  // write requests
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_WIDTH_A-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  // read requests
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [ADDR_WIDTH_A-1:0] rd_addr,
  // read responses
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  // SPRAM wrapper side
  output logic                    ram_ena,
  output logic                    ram_wea,
  output logic [ADDR_WIDTH_A-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0]   ram_dina,
  output logic                    ram_regcea,
  output logic                    ram_rsta,
  input  logic [DATA_WIDTH-1:0]   ram_douta,
  // status
  output logic                    busy
);

  localparam int unsigned PW = $clog2(RSP_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = CW + 1;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_t;

  grant_t                last_grant;
  grant_t                grant_nxt;

  logic [2:0]            rd_track;
  logic [1:0]            inflight;
  logic [CW-1:0]         rsp_count;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] rsp_mem [RSP_DEPTH];
  logic [OW-1:0]         occupancy;
  logic                  credit_ok;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  push;
  logic                  pop;

  assign ram_regcea = 1'b1;
  assign ram_rsta   = 1'b0;

  // Credit: reads in the RAM pipeline plus buffered responses must leave room.
  // A pop in the same cycle deliberately does not free a slot.
  always_comb begin
    inflight  = {1'b0, rd_track[0]} + {1'b0, rd_track[1]} + {1'b0, rd_track[2]};
    occupancy = OW'(inflight) + OW'(rsp_count);
    credit_ok = occupancy < OW'(RSP_DEPTH);
  end

  // Arbitration: on contention the type not granted last time wins.
  always_comb begin
    rd_ready  = credit_ok && !(wr_valid && (last_grant == GRANT_READ));
    wr_ready  = !(rd_valid && credit_ok && (last_grant == GRANT_WRITE));
    wr_fire   = wr_valid && wr_ready;
    rd_fire   = rd_valid && rd_ready;
    grant_nxt = last_grant;
    if (wr_fire) begin
      grant_nxt = GRANT_WRITE;
    end else if (rd_fire) begin
      grant_nxt = GRANT_READ;
    end
  end

  // Last-grant state register.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      last_grant <= GRANT_READ;
    end else begin
      last_grant <= grant_nxt;
    end
  end

  // Registered RAM command; write data is held across reads.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      ram_ena   <= 1'b0;
      ram_wea   <= 1'b0;
      ram_addra <= '0;
      ram_dina  <= '0;
    end else if (wr_fire) begin
      ram_ena   <= 1'b1;
      ram_wea   <= 1'b1;
      ram_addra <= wr_addr;
      ram_dina  <= wr_data;
    end else if (rd_fire) begin
      ram_ena   <= 1'b1;
      ram_wea   <= 1'b0;
      ram_addra <= rd_addr;
    end else begin
      ram_ena   <= 1'b0;
      ram_wea   <= 1'b0;
    end
  end

  // Read tracking: one stage for the command register, two for RAM latency.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      rd_track <= '0;
    end else begin
      rd_track <= {rd_track[1:0], rd_fire};
    end
  end

  always_comb begin
    push      = rd_track[2];
    rsp_valid = (rsp_count != '0);
    pop       = rsp_valid && rsp_ready;
    rsp_data  = rsp_mem[rd_ptr];
    busy      = (inflight != '0) || (rsp_count != '0);
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rsp_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   rsp_count <= rsp_count + 1'b1;
        2'b01:   rsp_count <= rsp_count - 1'b1;
        default: rsp_count <= rsp_count;
      endcase
    end
  end

  // Response FIFO storage; capture RAM output when a tracked read lands.
  always_ff @(posedge clka) begin
    if (push) begin
      rsp_mem[wr_ptr] <= ram_douta;
    end
  end

endmodule

// File: tb/tb_xpmwrap_spram_ctrl.sv
// Directed bench for xpmwrap_spram_ctrl. Instance 0 uses the default
// 4-entry response buffer; instance 1 uses 8 entries for streaming reads.
module tb_xpmwrap_spram_ctrl;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  logic          wr_valid  [2];
  logic          wr_ready  [2];
  logic [AW-1:0] wr_addr   [2];
  logic [DW-1:0] wr_data   [2];
  logic          rd_valid  [2];
  logic          rd_ready  [2];
  logic [AW-1:0] rd_addr   [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic [DW-1:0] rsp_data  [2];
  logic          ram_ena   [2];
  logic          ram_wea   [2];
  logic [AW-1:0] ram_addra [2];
  logic [DW-1:0] ram_dina  [2];
  logic          ram_regcea[2];
  logic          ram_rsta  [2];
  logic          busy      [2];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [DW-1:0] mem [64];
    logic [DW-1:0] q1;
    logic [DW-1:0] q2;

    // RAM model: address sampled one edge after the command, data out one edge later.
    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
        q1 <= '0;
        q2 <= '0;
      end else begin
        if (ram_ena[g]) begin
          if (ram_wea[g]) mem[ram_addra[g]] <= ram_dina[g];
          else            q1 <= mem[ram_addra[g]];
        end
        q2 <= q1;
      end
    end

    xpmwrap_spram_ctrl #(
      .ADDR_WIDTH_A(AW),
      .DATA_WIDTH  (DW),
      .RSP_DEPTH   ((g == 0) ? 4 : 8)
    ) dut (
      .clka      (clk),
      .rsta_n    (rst_n),
      .wr_valid  (wr_valid[g]),
      .wr_ready  (wr_ready[g]),
      .wr_addr   (wr_addr[g]),
      .wr_data   (wr_data[g]),
      .rd_valid  (rd_valid[g]),
      .rd_ready  (rd_ready[g]),
      .rd_addr   (rd_addr[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_data  (rsp_data[g]),
      .ram_ena   (ram_ena[g]),
      .ram_wea   (ram_wea[g]),
      .ram_addra (ram_addra[g]),
      .ram_dina  (ram_dina[g]),
      .ram_regcea(ram_regcea[g]),
      .ram_rsta  (ram_rsta[g]),
      .ram_douta (q2),
      .busy      (busy[g])
    );
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    mem_init = 1'b0;
    #3;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (ram_ena[k] !== 1'b0) begin n_bad++; $display("FAIL rst_ram_ena[%0d] got %b exp 0", k, ram_ena[k]); end
      n_cmp++; if (ram_wea[k] !== 1'b0) begin n_bad++; $display("FAIL rst_ram_wea[%0d] got %b exp 0", k, ram_wea[k]); end
      n_cmp++; if (ram_addra[k] !== 6'd0) begin n_bad++; $display("FAIL rst_ram_addra[%0d] got %h exp 0", k, ram_addra[k]); end
      n_cmp++; if (ram_dina[k] !== 32'h0) begin n_bad++; $display("FAIL rst_ram_dina[%0d] got %h exp 0", k, ram_dina[k]); end
      n_cmp++; if (rsp_valid[k] !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid[%0d] got %b exp 0", k, rsp_valid[k]); end
      n_cmp++; if (busy[k] !== 1'b0) begin n_bad++; $display("FAIL rst_busy[%0d] got %b exp 0", k, busy[k]); end
      n_cmp++; if (ram_regcea[k] !== 1'b1) begin n_bad++; $display("FAIL rst_regcea[%0d] got %b exp 1", k, ram_regcea[k]); end
      n_cmp++; if (ram_rsta[k] !== 1'b0) begin n_bad++; $display("FAIL rst_rsta[%0d] got %b exp 0", k, ram_rsta[k]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (wr_ready[0] !== 1'b1) begin n_bad++; $display("FAIL rel_wr_ready got %b exp 1", wr_ready[0]); end
    n_cmp++; if (rd_ready[0] !== 1'b1) begin n_bad++; $display("FAIL rel_rd_ready got %b exp 1", rd_ready[0]); end
    tick;
  endtask

  task automatic test_write_read;
    wr_valid[0] = 1'b1; wr_addr[0] = 6'd5; wr_data[0] = 32'hDEAD_BEEF; rsp_ready[0] = 1'b1;
    #1;
    n_cmp++; if (wr_ready[0] !== 1'b1) begin n_bad++; $display("FAIL wr_ready got %b exp 1", wr_ready[0]); end
    tick;
    n_cmp++; if (ram_ena[0] !== 1'b1) begin n_bad++; $display("FAIL wcmd_ena got %b exp 1", ram_ena[0]); end
    n_cmp++; if (ram_wea[0] !== 1'b1) begin n_bad++; $display("FAIL wcmd_wea got %b exp 1", ram_wea[0]); end
    n_cmp++; if (ram_addra[0] !== 6'd5) begin n_bad++; $display("FAIL wcmd_addr got %h exp 05", ram_addra[0]); end
    n_cmp++; if (ram_dina[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wcmd_din got %h exp deadbeef", ram_dina[0]); end
    wr_valid[0] = 1'b0; rd_valid[0] = 1'b1; rd_addr[0] = 6'd5;
    #1;
    n_cmp++; if (rd_ready[0] !== 1'b1) begin n_bad++; $display("FAIL rd_ready got %b exp 1", rd_ready[0]); end
    tick;
    rd_valid[0] = 1'b0;
    n_cmp++; if (ram_ena[0] !== 1'b1) begin n_bad++; $display("FAIL rcmd_ena got %b exp 1", ram_ena[0]); end
    n_cmp++; if (ram_wea[0] !== 1'b0) begin n_bad++; $display("FAIL rcmd_wea got %b exp 0", ram_wea[0]); end
    n_cmp++; if (ram_addra[0] !== 6'd5) begin n_bad++; $display("FAIL rcmd_addr got %h exp 05", ram_addra[0]); end
    n_cmp++; if (ram_dina[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rcmd_din_hold got %h exp deadbeef", ram_dina[0]); end
    n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL rd_busy got %b exp 1", busy[0]); end
    n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL lat1_valid got %b exp 0", rsp_valid[0]); end
    tick;
    n_cmp++; if (ram_ena[0] !== 1'b0) begin n_bad++; $display("FAIL idle_ena got %b exp 0", ram_ena[0]); end
    n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL lat2_valid got %b exp 0", rsp_valid[0]); end
    tick;
    n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL lat3_valid got %b exp 0", rsp_valid[0]); end
    tick;
    n_cmp++; if (rsp_valid[0] !== 1'b1) begin n_bad++; $display("FAIL lat_valid got %b exp 1", rsp_valid[0]); end
    n_cmp++; if (rsp_data[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_rd_data got %h exp deadbeef", rsp_data[0]); end
    tick;
    n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL popped_valid got %b exp 0", rsp_valid[0]); end
    n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL popped_busy got %b exp 0", busy[0]); end
  endtask

  task automatic test_credit;
    int acc;
    acc = 0;
    rsp_ready[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_valid[0] = 1'b1; rd_addr[0] = 6'(i);
      #1;
      if (rd_ready[0] === 1'b1) acc++;
      tick;
    end
    rd_valid[0] = 1'b0;
    #1;
    n_cmp++; if (acc !== 4) begin n_bad++; $display("FAIL credit_accepts got %0d exp 4", acc); end
    n_cmp++; if (rd_ready[0] !== 1'b0) begin n_bad++; $display("FAIL credit_rd_ready got %b exp 0", rd_ready[0]); end
    n_cmp++; if (rsp_valid[0] !== 1'b1) begin n_bad++; $display("FAIL credit_valid got %b exp 1", rsp_valid[0]); end
    n_cmp++; if (rsp_data[0] !== 32'h1000_0000) begin n_bad++; $display("FAIL credit_head got %h exp 10000000", rsp_data[0]); end
    n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL credit_busy got %b exp 1", busy[0]); end
    tick;
    n_cmp++; if (rsp_data[0] !== 32'h1000_0000) begin n_bad++; $display("FAIL stall_stable got %h exp 10000000", rsp_data[0]); end
    rsp_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (rsp_valid[0] !== 1'b1) begin n_bad++; $display("FAIL drain_valid[%0d] got %b exp 1", k, rsp_valid[0]); end
      n_cmp++; if (rsp_data[0] !== 32'h1000_0000 + k) begin n_bad++; $display("FAIL drain_data[%0d] got %h exp %h", k, rsp_data[0], 32'h1000_0000 + k); end
      tick;
    end
    #1;
    n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL drained_valid got %b exp 0", rsp_valid[0]); end
    n_cmp++; if (rd_ready[0] !== 1'b1) begin n_bad++; $display("FAIL drained_rd_ready got %b exp 1", rd_ready[0]); end
    n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL drained_busy got %b exp 0", busy[0]); end
    tick;
  endtask

  task automatic test_contention;
    int got;
    logic exp_w;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    wr_valid[0] = 1'b1; wr_addr[0] = 6'd20; rd_valid[0] = 1'b1; rd_addr[0] = 6'd21; rsp_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_w = ((k % 2) == 0);
      wr_data[0] = 32'hCAFE_0000 + k;
      #1;
      n_cmp++; if (wr_ready[0] !== exp_w) begin n_bad++; $display("FAIL arb_wr_ready[%0d] got %b exp %b", k, wr_ready[0], exp_w); end
      n_cmp++; if (rd_ready[0] !== !exp_w) begin n_bad++; $display("FAIL arb_rd_ready[%0d] got %b exp %b", k, rd_ready[0], !exp_w); end
      tick;
      n_cmp++; if (ram_ena[0] !== 1'b1) begin n_bad++; $display("FAIL arb_ena[%0d] got %b exp 1", k, ram_ena[0]); end
      n_cmp++; if (ram_wea[0] !== exp_w) begin n_bad++; $display("FAIL arb_wea[%0d] got %b exp %b", k, ram_wea[0], exp_w); end
    end
    wr_valid[0] = 1'b0; rd_valid[0] = 1'b0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rsp_valid[0] === 1'b1) begin
        n_cmp++; if (rsp_data[0] !== 32'h1000_0015) begin n_bad++; $display("FAIL arb_rsp[%0d] got %h exp 10000015", got, rsp_data[0]); end
        got++;
      end
      tick;
    end
    n_cmp++; if (got !== 2) begin n_bad++; $display("FAIL arb_rsp_count got %0d exp 2", got); end
    n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL arb_busy got %b exp 0", busy[0]); end
  endtask

  task automatic test_reset_flush;
    rsp_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_valid[0] = 1'b1; rd_addr[0] = 6'(8 + i);
      tick;
    end
    rd_valid[0] = 1'b0;
    tick;
    n_cmp++; if (rsp_valid[0] !== 1'b1) begin n_bad++; $display("FAIL flush_pre_valid got %b exp 1", rsp_valid[0]); end
    n_cmp++; if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL flush_pre_busy got %b exp 1", busy[0]); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b exp 0", rsp_valid[0]); end
    n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL flush_busy got %b exp 0", busy[0]); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (wr_ready[0] !== 1'b1) begin n_bad++; $display("FAIL flush_wr_ready got %b exp 1", wr_ready[0]); end
    n_cmp++; if (rd_ready[0] !== 1'b1) begin n_bad++; $display("FAIL flush_rd_ready got %b exp 1", rd_ready[0]); end
    rsp_ready[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick;
      n_cmp++; if (rsp_valid[0] !== 1'b0) begin n_bad++; $display("FAIL stale_valid[%0d] got %b exp 0", c, rsp_valid[0]); end
      n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL stale_busy[%0d] got %b exp 0", c, busy[0]); end
    end
  endtask

  task automatic test_back_to_back;
    int acc;
    int got;
    int first;
    int last;
    acc = 0; got = 0; first = -1; last = -1;
    rsp_ready[1] = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          rd_valid[1] = 1'b1; rd_addr[1] = 6'(i);
          #1;
          if (rd_ready[1] === 1'b1) acc++;
          tick;
        end
        rd_valid[1] = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && got < 16; c++) begin
          @(negedge clk);
          if (rsp_valid[1] === 1'b1) begin
            n_cmp++; if (rsp_data[1] !== 32'h1000_0000 + got) begin n_bad++; $display("FAIL b2b_data[%0d] got %h exp %h", got, rsp_data[1], 32'h1000_0000 + got); end
            if (got == 0) first = c;
            last = c;
            got++;
          end
        end
        @(negedge clk);
        n_cmp++; if (busy[1] !== 1'b0) begin n_bad++; $display("FAIL b2b_busy got %b exp 0", busy[1]); end
        n_cmp++; if (rsp_valid[1] !== 1'b0) begin n_bad++; $display("FAIL b2b_tail_valid got %b exp 0", rsp_valid[1]); end
      end
    join
    n_cmp++; if (acc !== 16) begin n_bad++; $display("FAIL b2b_accepts got %0d exp 16", acc); end
    n_cmp++; if (got !== 16) begin n_bad++; $display("FAIL b2b_responses got %0d exp 16", got); end
    n_cmp++; if (last - first !== 15) begin n_bad++; $display("FAIL b2b_span got %0d exp 15", last - first); end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      wr_valid[k] = 1'b0; wr_addr[k] = '0; wr_data[k] = '0;
      rd_valid[k] = 1'b0; rd_addr[k] = '0; rsp_ready[k] = 1'b0;
    end
    test_reset;
    test_write_read;
    test_credit;
    test_contention;
    test_reset_flush;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
